// File: rtl/pc_call_stack.sv
// Next-PC unit: sequential / NZP-conditional branch / CALL / RET selection, with an NZP flag register.
// Define PC_CALL_STACK_EN to build the return-address stack; without it CALL is a plain jump and RET is sequential.
module pc_call_stack #(
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH           = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [2:0]                         core_state,
  input  logic [2:0]                         decoded_nzp,
  input  logic [DATA_MEM_DATA_BITS-1:0]      decoded_immediate,
  input  logic                               decoded_nzp_write_enable,
  input  logic [1:0]                         decoded_pc_mux,
  input  logic [DATA_MEM_DATA_BITS-1:0]      alu_out,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]   current_pc,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]   next_pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);
  localparam int         AW            = PROGRAM_MEM_ADDR_BITS;
  localparam int         DEPTH_BITS    = $clog2(STACK_DEPTH + 1);
  localparam logic [2:0] STATE_EXECUTE = 3'b101;
  localparam logic [2:0] STATE_UPDATE  = 3'b110;

  typedef enum logic [1:0] {
    MUX_SEQ    = 2'b00,
    MUX_BRANCH = 2'b01,
    MUX_CALL   = 2'b10,
    MUX_RET    = 2'b11
  } pc_mux_e;

  pc_mux_e       pc_mux;
  logic [AW-1:0] seq_pc, target_pc;
  logic [AW-1:0] next_pc_q, next_pc_d;
  logic [2:0]    nzp_q, nzp_d;
  logic          do_execute, do_update;

  assign pc_mux     = pc_mux_e'(decoded_pc_mux);
  assign do_execute = enable && (core_state == STATE_EXECUTE);
  assign do_update  = enable && (core_state == STATE_UPDATE) && decoded_nzp_write_enable;
  assign seq_pc     = current_pc + AW'(1);
  // Size cast zero-extends a narrow immediate and truncates a wide one.
  assign target_pc  = AW'(decoded_immediate);

`ifdef PC_CALL_STACK_EN
  localparam int                    IDX_BITS = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_BITS-1:0] FULL     = DEPTH_BITS'(STACK_DEPTH);

  logic [AW-1:0]         stack_q [STACK_DEPTH];
  logic [DEPTH_BITS-1:0] depth_q, depth_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  push;
  logic [IDX_BITS-1:0]   push_idx, top_idx;

  assign push_idx = IDX_BITS'(depth_q);
  assign top_idx  = IDX_BITS'(depth_q - DEPTH_BITS'(1));
`endif

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path through the block can infer a latch.
    next_pc_d = next_pc_q;
    nzp_d     = nzp_q;
`ifdef PC_CALL_STACK_EN
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
`endif
    if (do_execute) begin
      unique case (pc_mux)
        MUX_SEQ:    next_pc_d = seq_pc;
        MUX_BRANCH: next_pc_d = ((nzp_q & decoded_nzp) != 3'b000) ? target_pc : seq_pc;
`ifdef PC_CALL_STACK_EN
        MUX_CALL: begin
          if (depth_q != FULL) begin
            push      = 1'b1;
            depth_d   = depth_q + DEPTH_BITS'(1);
            next_pc_d = target_pc;
          end else begin
            next_pc_d = seq_pc;
            ovf_d     = 1'b1;
          end
        end
        MUX_RET: begin
          if (depth_q != '0) begin
            next_pc_d = stack_q[top_idx];
            depth_d   = depth_q - DEPTH_BITS'(1);
          end else begin
            next_pc_d = seq_pc;
            unf_d     = 1'b1;
          end
        end
`else
        MUX_CALL:   next_pc_d = target_pc;
        MUX_RET:    next_pc_d = seq_pc;
`endif
        default:    next_pc_d = next_pc_q;
      endcase
    end
    // UPDATE and EXECUTE are distinct phases, so a branch always sees the previously registered NZP.
    if (do_update) nzp_d = alu_out[2:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc_q <= '0;
      nzp_q     <= '0;
    end else begin
      next_pc_q <= next_pc_d;
      nzp_q     <= nzp_d;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: the return-address storage is intentionally not reset; depth_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= seq_pc;
  end

  assign stack_depth     = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
`else
  assign stack_depth     = '0;
  assign stack_overflow  = 1'b0;
  assign stack_underflow = 1'b0;
`endif

  assign next_pc = next_pc_q;

endmodule
